// File: rtl/level1.sv
// level1: saturating fixed-point adder.
// Both operands are aligned to the output exponent and added at full precision.
// The sum is clamped to the signed C_WIDTH range and is available combinationally
// on c. A clock-enabled register holds a copy of c, and a second register keeps a
// sticky record of any saturation.
module level1 #(
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9,
  parameter int C_WIDTH = 18,
  parameter int C_EXP   = -10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cke,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic signed [C_WIDTH-1:0] c,
  output logic signed [C_WIDTH-1:0] c_q,
  output logic                      ovf,
  output logic                      ovf_sticky
);

  // A left shift grows the operand. A right shift never needs extra bits.
  localparam int A_LS = (A_EXP > C_EXP) ? (A_EXP - C_EXP) : 0;
  localparam int B_LS = (B_EXP > C_EXP) ? (B_EXP - C_EXP) : 0;
  localparam int A_AW = A_WIDTH + A_LS;
  localparam int B_AW = B_WIDTH + B_LS;
  localparam int AB_W = (A_AW > B_AW) ? A_AW : B_AW;
  localparam int FW   = (AB_W > C_WIDTH) ? AB_W : C_WIDTH;

  logic signed [FW-1:0] a_ext, b_ext, a_al, b_al;
  logic        [FW:0]   sum;
  logic        [FW-C_WIDTH+1:0] sum_hi;
  logic signed [C_WIDTH-1:0] c_d;
  logic                      ovf_sticky_d, ovf_sticky_q;

  assign a_ext = FW'(a);
  assign b_ext = FW'(b);

  // Operand alignment. A right shift floors toward minus infinity.
  if (A_EXP >= C_EXP) begin : g_a_left
    assign a_al = a_ext <<< (A_EXP - C_EXP);
  end else begin : g_a_right
    assign a_al = a_ext >>> (C_EXP - A_EXP);
  end

  if (B_EXP >= C_EXP) begin : g_b_left
    assign b_al = b_ext <<< (B_EXP - C_EXP);
  end else begin : g_b_right
    assign b_al = b_ext >>> (C_EXP - B_EXP);
  end

  // The full-precision sum is one bit wider than either aligned operand,
  // so the addition itself cannot overflow.
  assign sum    = {a_al[FW-1], a_al} + {b_al[FW-1], b_al};
  assign sum_hi = sum[FW:C_WIDTH-1];

  // Saturation: the sum fits only when all bits from the C sign bit upward agree.
  always_comb begin
    ovf = !((&sum_hi) || !(|sum_hi));
    c   = sum[C_WIDTH-1:0];
    if (ovf) c = sum[FW] ? {1'b1, {(C_WIDTH-1){1'b0}}} : {1'b0, {(C_WIDTH-1){1'b1}}};
  end

  // Next state for the registered outputs. The registers hold when cke is low.
  always_comb begin
    c_d          = c_q;
    ovf_sticky_d = ovf_sticky_q;
    if (cke) begin
      c_d          = c;
      ovf_sticky_d = ovf_sticky_q | ovf;
    end
  end

  // State registers. The synchronous reset takes priority over cke.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q          <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      c_q          <= c_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_level1.sv
// tb_level1: scoreboard bench for the level1 saturating adder.
// Expected register values are queued when stimulus is driven and compared after the edge.
module tb_level1;

  localparam longint CMAX = 131071;
  localparam longint CMIN = -131072;

  typedef struct {
    longint cq;
    logic   st;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, cke = 1'b0;
  logic signed [15:0] a = '0, a2 = '0;
  logic signed [16:0] b = '0, b2 = '0;
  logic signed [17:0] c, c_q, c2, c2_q;
  logic ovf, ovf_sticky, ovf2, st2;

  int total = 0, bad = 0;
  exp_t sbq[$];
  longint m_cq = 0;
  logic   m_st = 1'b0;

  always #5 clk = ~clk;

  level1 dut (
    .clk(clk), .rst(rst), .cke(cke), .a(a), .b(b),
    .c(c), .c_q(c_q), .ovf(ovf), .ovf_sticky(ovf_sticky)
  );

  level1 #(.C_EXP(-8)) dut8 (
    .clk(clk), .rst(rst), .cke(cke), .a(a2), .b(b2),
    .c(c2), .c_q(c2_q), .ovf(ovf2), .ovf_sticky(st2)
  );

  // Reference model: align both operands, add, then saturate to 18 bits.
  function automatic longint align(input longint v, input int sh);
    if (sh >= 0) return v <<< sh;
    return v >>> (-sh);
  endfunction

  function automatic longint raw_sum(input longint av, input longint bv, input int ash, input int bsh);
    return align(av, ash) + align(bv, bsh);
  endfunction

  function automatic longint sat(input longint s);
    if (s > CMAX) return CMAX;
    if (s < CMIN) return CMIN;
    return s;
  endfunction

  function automatic logic is_ovf(input longint s);
    return (s > CMAX) || (s < CMIN);
  endfunction

  // Check c and ovf of the default instance against the model, with no clock edge.
  task automatic test_comb_now(input string nm);
    longint s;
    s = raw_sum(longint'(a), longint'(b), 2, 1);
    #1;
    total++;
    if (longint'(c) !== sat(s)) begin
      bad++; $display("FAIL %s c: got %0d want %0d", nm, c, sat(s));
    end
    total++;
    if (ovf !== is_ovf(s)) begin
      bad++; $display("FAIL %s ovf: got %0b want %0b", nm, ovf, is_ovf(s));
    end
  endtask

  // Apply one edge with the given rst and cke, then pop the expectation and compare.
  task automatic step(input logic r, input logic k);
    exp_t e;
    longint s;
    rst = r; cke = k;
    s = raw_sum(longint'(a), longint'(b), 2, 1);
    if (r) begin
      m_cq = 0; m_st = 1'b0;
    end else if (k) begin
      m_cq = sat(s); m_st = m_st | is_ovf(s);
    end
    sbq.push_back('{m_cq, m_st});
    @(posedge clk); #1;
    e = sbq.pop_front();
    total++;
    if (longint'(c_q) !== e.cq) begin
      bad++; $display("FAIL step c_q: got %0d want %0d", c_q, e.cq);
    end
    total++;
    if (ovf_sticky !== e.st) begin
      bad++; $display("FAIL step ovf_sticky: got %0b want %0b", ovf_sticky, e.st);
    end
  endtask

  task automatic test_reset;
    a = 16'sd100; b = 17'sd7;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic test_basic;
    a = 16'sd315; b = 17'sd2335;
    #1;
    total++;
    if (c !== 18'sd5930) begin bad++; $display("FAIL basic c: got %0d want 5930", c); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL basic ovf: got %0b want 0", ovf); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    total++;
    if (c_q !== 18'sd5930) begin bad++; $display("FAIL basic c_q: got %0d want 5930", c_q); end
  endtask

  task automatic test_sat_pos;
    a = 16'sd32767; b = 17'sd65535;
    #1;
    total++;
    if (c !== 18'sd131071 || ovf !== 1'b1) begin
      bad++; $display("FAIL sat_pos c/ovf: got %0d/%0b want 131071/1", c, ovf);
    end
    step(1'b0, 1'b1);
    a = '0; b = '0;
    test_comb_now("sat_pos_zero");
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    total++;
    if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_hold: got %0b want 1", ovf_sticky); end
  endtask

  task automatic test_sat_neg;
    a = -16'sd32768; b = -17'sd65536;
    #1;
    total++;
    if (c !== -18'sd131072 || ovf !== 1'b1) begin
      bad++; $display("FAIL sat_neg c/ovf: got %0d/%0b want -131072/1", c, ovf);
    end
    // Reset while cke is high still clears the registers.
    step(1'b1, 1'b1);
  endtask

  task automatic test_cke_hold;
    a = 16'sd1000; b = 17'sd3;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = 16'(i * 9000 - 20000); b = 17'(i * 40000 - 60000);
      test_comb_now("cke_hold_comb");
      step(1'b0, 1'b0);
    end
    a = 16'sd32767; b = 17'sd65535;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    total++;
    if (c_q !== '0 || ovf_sticky !== 1'b0) begin
      bad++; $display("FAIL rst_no_cke: got %0d/%0b want 0/0", c_q, ovf_sticky);
    end
  endtask

  // Reset must not disturb the combinational outputs.
  task automatic test_rst_comb;
    a = -16'sd1234; b = 17'sd4321;
    rst = 1'b1;
    test_comb_now("rst_comb");
    step(1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 17'($urandom);
      if (i % 5 == 0) begin a = 16'sh7ff0; b = 17'sh0fff0; end
      test_comb_now("rand_comb");
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic test_param_floor;
    longint s;
    a2 = 16'sd1; b2 = 17'sd1;
    #1;
    total++;
    if (c2 !== 18'sd1 || ovf2 !== 1'b0) begin
      bad++; $display("FAIL floor_pos: got %0d/%0b want 1/0", c2, ovf2);
    end
    a2 = -16'sd1; b2 = -17'sd1;
    #1;
    total++;
    if (c2 !== -18'sd2) begin bad++; $display("FAIL floor_neg: got %0d want -2", c2); end
    a2 = 16'sd5; b2 = -17'sd3;
    s = raw_sum(longint'(a2), longint'(b2), 0, -1);
    #1;
    total++;
    if (longint'(c2) !== sat(s)) begin bad++; $display("FAIL floor_mix: got %0d want %0d", c2, sat(s)); end
    step(1'b0, 1'b1);
    total++;
    if (longint'(c2_q) !== sat(s) || st2 !== 1'b0) begin
      bad++; $display("FAIL floor_reg: got %0d/%0b want %0d/0", c2_q, st2, sat(s));
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_sat_pos();
    test_sat_neg();
    test_cke_hold();
    test_rst_comb();
    test_back_to_back();
    step(1'b1, 1'b0);
    test_param_floor();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
